// File: rtl/psg_sched_pkg.sv
// Shared types and constants for the PSG per-frame mix scheduler.
package psg_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACC    = 2'd2,
    ST_COMMIT = 2'd3
  } sched_state_t;

  localparam int SAMPLE_W = 8;
  localparam int MIX_W    = 16;
  localparam int ACC_W    = 18;

  localparam logic [MIX_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [MIX_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/tt_um_accelshark_psg_sat16.sv
// Combinational 18-bit signed to 16-bit signed saturator.
module tt_um_accelshark_psg_sat16
  import psg_sched_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  output logic [MIX_W-1:0] o_mix
);

  logic w_pos_ovf;
  logic w_neg_ovf;

  // The value fits in 16 bits only when every bit above bit 15 matches the sign.
  assign w_pos_ovf = !i_acc[ACC_W-1] && (i_acc[ACC_W-2:MIX_W-1] != '0);
  assign w_neg_ovf =  i_acc[ACC_W-1] && (i_acc[ACC_W-2:MIX_W-1] != '1);

  always_comb begin
    o_mix = i_acc[MIX_W-1:0];
    if (w_pos_ovf) begin
      o_mix = SAT_MAX;
    end else if (w_neg_ovf) begin
      o_mix = SAT_MIN;
    end
  end

endmodule

// File: rtl/tt_um_accelshark_psg_mix_sched.sv
// Per-frame round-robin PSG voice poller, L/R pan mixer and 16-bit saturating commit.
// Optional REQ timeout is built only when PSG_SCHED_TIMEOUT_EN is defined.
module tt_um_accelshark_psg_mix_sched
  import psg_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int GAIN_SHIFT = 6
`ifdef PSG_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
  ,
  localparam int IDX_W = $clog2(NUM_VOICES)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  frame_strobe,
  output logic [NUM_VOICES-1:0] voice_req,
  output logic [IDX_W-1:0]      voice_sel,
  input  logic [NUM_VOICES-1:0] voice_ack,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [1:0]            cfg_wdata,
  input  logic                  flag_clr,
  output logic [MIX_W-1:0]      mix_l,
  output logic [MIX_W-1:0]      mix_r,
  output logic                  mix_valid,
  output logic                  overrun,
  output logic                  timeout,
  output logic [1:0]            dbg_state
);

  // Handshake: voice_req[i] stays high while voice i (= voice_sel) is polled; the poll
  // completes on the first cycle voice_ack[i] is high, with voice_sample valid in that
  // same cycle. Acks on any other line are ignored.

  sched_state_t r_state, w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [NUM_VOICES-1:0][1:0] r_pan, r_pan_snap;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r, w_scaled;
  logic [SAMPLE_W-1:0] r_sample;
  logic [MIX_W-1:0] r_mix_l, r_mix_r, w_sat_l, w_sat_r;
  logic r_mix_valid, r_overrun;
  logic w_start, w_abort, w_capture, w_to_hit, w_timeout_set, w_overrun_set, w_commit;
  logic w_last;

  assign w_last   = (r_idx == IDX_W'(NUM_VOICES - 1));
  assign w_scaled = {{(ACC_W-SAMPLE_W){r_sample[SAMPLE_W-1]}}, r_sample} << GAIN_SHIFT;

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_abort       = 1'b0;
    w_capture     = 1'b0;
    w_timeout_set = 1'b0;
    w_overrun_set = 1'b0;
    w_commit      = 1'b0;
    if (!ena) begin
      w_next_state = ST_IDLE;
      w_abort      = (r_state != ST_IDLE);
    end else begin
      case (r_state)
        ST_IDLE: if (frame_strobe) begin
          w_next_state = ST_REQ;
          w_start      = 1'b1;
        end
        ST_REQ: if (voice_ack[r_idx]) begin
          w_capture    = 1'b1;
          w_next_state = ST_ACC;
        end else if (w_to_hit) begin
          w_timeout_set = 1'b1;
          w_next_state  = ST_ACC;
        end
        ST_ACC: w_next_state = w_last ? ST_COMMIT : ST_REQ;
        ST_COMMIT: begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
      // A strobe mid-frame restarts the frame; a commit in progress still lands.
      if (frame_strobe && (r_state != ST_IDLE)) begin
        w_overrun_set = 1'b1;
        w_start       = 1'b1;
        w_capture     = 1'b0;
        w_timeout_set = 1'b0;
        w_next_state  = ST_REQ;
      end
    end
  end

  always_comb begin
    voice_req = '0;
    if ((r_state == ST_REQ) && ena) begin
      voice_req[r_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pan       <= {NUM_VOICES{2'b11}};
      r_pan_snap  <= {NUM_VOICES{2'b11}};
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_sample    <= '0;
      r_mix_l     <= '0;
      r_mix_r     <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mix_valid <= w_commit;
      if (cfg_we) begin
        r_pan[cfg_addr] <= cfg_wdata;
      end
      if (w_capture) begin
        r_sample <= voice_sample;
      end else if (w_timeout_set) begin
        r_sample <= '0;
      end
      if (w_commit) begin
        r_mix_l <= w_sat_l;
        r_mix_r <= w_sat_r;
      end
      if (w_start) begin
        r_pan_snap <= r_pan;
        r_acc_l    <= '0;
        r_acc_r    <= '0;
        r_idx      <= '0;
      end else if (w_abort) begin
        r_idx <= '0;
      end else if (r_state == ST_ACC) begin
        if (r_pan_snap[r_idx][0]) r_acc_l <= r_acc_l + w_scaled;
        if (r_pan_snap[r_idx][1]) r_acc_r <= r_acc_r + w_scaled;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Sticky flags: a new event in the same cycle as flag_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun_set | (r_overrun & ~flag_clr);
    end
  end

`ifdef PSG_SCHED_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= ((r_state == ST_REQ) && (w_next_state == ST_REQ) && !w_start)
                   ? r_to_cnt + TO_W'(1) : '0;
      r_timeout <= w_timeout_set | (r_timeout & ~flag_clr);
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  tt_um_accelshark_psg_sat16 u_sat_l (.i_acc(r_acc_l), .o_mix(w_sat_l));
  tt_um_accelshark_psg_sat16 u_sat_r (.i_acc(r_acc_r), .o_mix(w_sat_r));

  assign voice_sel = r_idx;
  assign mix_l     = r_mix_l;
  assign mix_r     = r_mix_r;
  assign mix_valid = r_mix_valid;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tt_um_accelshark_psg_mix_sched.sv
// Bench for the PSG mix scheduler: two instances (GAIN_SHIFT 6 and 8) share stimulus and
// are checked against a frame-level mixing model. Covers PSG_SCHED_TIMEOUT_EN builds too.
module tb_tt_um_accelshark_psg_mix_sched;

  localparam int NV  = 4;
  localparam int LAT = 2 * NV + 2;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst, ena, frame_strobe, cfg_we, flag_clr;
  logic [1:0] cfg_addr, cfg_wdata;
  logic [NV-1:0] voice_ack = '0;
  logic [7:0] voice_sample = '0;

  logic [NV-1:0] voice_req, voice_req8;
  logic [1:0] voice_sel, voice_sel8, dbg_state, dbg_state8;
  logic [15:0] mix_l, mix_r, mix_l8, mix_r8;
  logic mix_valid, mix_valid8, overrun, overrun8, timeout, timeout8;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tt_um_accelshark_psg_mix_sched #(.NUM_VOICES(NV), .GAIN_SHIFT(6)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .frame_strobe(frame_strobe),
    .voice_req(voice_req), .voice_sel(voice_sel), .voice_ack(voice_ack),
    .voice_sample(voice_sample), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .flag_clr(flag_clr), .mix_l(mix_l), .mix_r(mix_r),
    .mix_valid(mix_valid), .overrun(overrun), .timeout(timeout), .dbg_state(dbg_state)
  );

  tt_um_accelshark_psg_mix_sched #(.NUM_VOICES(NV), .GAIN_SHIFT(8)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena), .frame_strobe(frame_strobe),
    .voice_req(voice_req8), .voice_sel(voice_sel8), .voice_ack(voice_ack),
    .voice_sample(voice_sample), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .flag_clr(flag_clr), .mix_l(mix_l8), .mix_r(mix_r8),
    .mix_valid(mix_valid8), .overrun(overrun8), .timeout(timeout8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  logic [15:0] last_exp_l = '0;
  logic [15:0] last_exp_r = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int samp_m[NV];
  int dly_m[NV];
  bit silent_m[NV];
  logic [1:0] pan_m[NV];
  bit noise_en = 1'b0;

  function automatic logic [15:0] model_mix(input int gs, input int side);
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++)
      if (!silent_m[v] && pan_m[v][side]) sum += samp_m[v] * (1 << gs);
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  task automatic push_exp();
    logic [15:0] l6, r6;
    l6 = model_mix(6, 0);
    r6 = model_mix(6, 1);
    exp_q.push_back({l6, r6, model_mix(8, 0), model_mix(8, 1)});
    last_exp_l = l6;
    last_exp_r = r6;
  endtask

  // ---------------- voice responder ----------------
  int req_cnt = 0;
  always @(negedge clk) begin
    logic [NV-1:0] noise;
    int rv;
    noise = noise_en ? NV'($urandom) : '0;
    voice_sample = 8'($urandom);
    voice_ack = '0;
    rv = -1;
    for (int i = 0; i < NV; i++) if (voice_req[i]) rv = i;
    if (rv >= 0) begin
      if (req_cnt == 0) begin
        chk("req_onehot", 32'($onehot(voice_req)), 32'd1);
        chk("voice_sel", 32'(voice_sel), 32'(rv));
      end
      noise &= ~voice_req;
      if (req_cnt >= dly_m[rv] && !silent_m[rv]) begin
        voice_ack[rv] = 1'b1;
        voice_sample = 8'(samp_m[rv]);
      end
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
    voice_ack |= noise;
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && mix_valid) begin
      last_valid_cyc = cyc;
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(mix_valid), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("mix_l", 32'(mix_l), 32'(e[63:48]));
        chk("mix_r", 32'(mix_r), 32'(e[47:32]));
        chk("valid_g8", 32'(mix_valid8), 32'd1);
        chk("mix_l_g8", 32'(mix_l8), 32'(e[31:16]));
        chk("mix_r_g8", 32'(mix_r8), 32'(e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(output int c);
    frame_strobe = 1'b1;
    c = cyc;
    @(negedge clk);
    frame_strobe = 1'b0;
  endtask

  task automatic wait_done(input int c, input int lat);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("frame_done", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end else if (lat > 0) begin
      chk("latency", 32'(last_valid_cyc - c), 32'(lat));
    end
  endtask

  task automatic run_frame(input bit lat_chk);
    int c;
    push_exp();
    strobe(c);
    wait_done(c, lat_chk ? LAT : 0);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    pan_m[a] = d;
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
  endtask

  task automatic set_samples(input int a, input int b, input int c, input int d);
    samp_m[0] = a; samp_m[1] = b; samp_m[2] = c; samp_m[3] = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, v0;
    rst = 1'b1; ena = 1'b1; frame_strobe = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; flag_clr = 1'b0;
    for (int v = 0; v < NV; v++) begin
      samp_m[v] = 0; dly_m[v] = 0; silent_m[v] = 1'b0; pan_m[v] = 2'b11;
    end
    tick(3);
    chk("rst_mix_l", 32'(mix_l), 32'd0);
    chk("rst_mix_r", 32'(mix_r), 32'd0);
    chk("rst_valid", 32'(mix_valid), 32'd0);
    chk("rst_req", 32'(voice_req), 32'd0);
    chk("rst_sel", 32'(voice_sel), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick(1);

    // Basic frame, default pans, latency 2*NV+2.
    set_samples(10, -20, 30, -40);
    run_frame(1'b1);
    chk("t1_mix_l", 32'(mix_l), 32'h0000FB00);
    chk("t1_mix_r", 32'(mix_r), 32'h0000FB00);
    tick(3);
    chk("t1_hold_l", 32'(mix_l), 32'h0000FB00);
    chk("t1_valid_pulse", 32'(mix_valid), 32'd0);

    // Single-sided pans.
    cfg_write(2'd0, 2'b01); cfg_write(2'd1, 2'b10);
    cfg_write(2'd2, 2'b00); cfg_write(2'd3, 2'b00);
    set_samples(127, -128, 55, -7);
    run_frame(1'b1);
    chk("t2_mix_l", 32'(mix_l), 32'd8128);
    chk("t2_mix_r", 32'(mix_r), 32'h0000E000);

    // Saturation at both rails (GAIN_SHIFT 8 instance).
    for (int v = 0; v < NV; v++) cfg_write(2'(v), 2'b11);
    set_samples(127, 127, 127, 127);
    run_frame(1'b1);
    chk("t3_sat_pos", 32'(mix_l8), 32'h00007FFF);
    set_samples(-128, -128, -128, -128);
    run_frame(1'b1);
    chk("t3_sat_neg", 32'(mix_r8), 32'h00008000);

    // Second strobe mid-frame: aborted frame gives no valid, restart commits at cycle 15.
    set_samples(33, -71, 5, 90);
    v0 = valid_cnt;
    push_exp();
    strobe(c);
    tick(4);
    frame_strobe = 1'b1;
    tick(1);
    frame_strobe = 1'b0;
    wait_done(c, LAT + 5);
    chk("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("t4_overrun", 32'(overrun), 32'd1);
    clear_flags();
    chk("t4_overrun_clr", 32'(overrun), 32'd0);

    // flag_clr in the same cycle as a new overrun: set wins.
    push_exp();
    strobe(c);
    tick(3);
    frame_strobe = 1'b1;
    flag_clr = 1'b1;
    tick(1);
    frame_strobe = 1'b0;
    flag_clr = 1'b0;
    wait_done(c, LAT + 4);
    chk("t4b_set_wins", 32'(overrun), 32'd1);
    clear_flags();

    // Strobe during COMMIT: first commit lands, overrun set, new frame follows.
    v0 = valid_cnt;
    push_exp();
    push_exp();
    strobe(c);
    tick(8);
    frame_strobe = 1'b1;
    tick(1);
    frame_strobe = 1'b0;
    wait_done(c, 0);
    chk("t4c_valid_count", 32'(valid_cnt - v0), 32'd2);
    chk("t4c_second_lat", 32'(last_valid_cyc - c), 32'(LAT + LAT - 1));
    chk("t4c_overrun", 32'(overrun), 32'd1);
    clear_flags();

    // Pan change mid-frame only affects the next frame.
    set_samples(40, -3, 17, 100);
    push_exp();
    strobe(c);
    tick(2);
    cfg_write(2'd1, 2'b00);
    cfg_write(2'd3, 2'b01);
    wait_done(c, LAT);
    run_frame(1'b1);

    // ena low mid-frame: abort, no flags, mix held.
    v0 = valid_cnt;
    strobe(c);
    tick(2);
    ena = 1'b0;
    #1;
    chk("ena_req_off", 32'(voice_req), 32'd0);
    tick(3);
    ena = 1'b1;
    tick(LAT + 4);
    chk("ena_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("ena_mix_held_l", 32'(mix_l), 32'(last_exp_l));
    chk("ena_mix_held_r", 32'(mix_r), 32'(last_exp_r));
    chk("ena_no_overrun", 32'(overrun), 32'd0);

    // Reset mid-frame returns everything to reset values, pans back to 11.
    strobe(c);
    tick(3);
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(voice_req), 32'd0);
    chk("mrst_sel", 32'(voice_sel), 32'd0);
    chk("mrst_mix_l", 32'(mix_l), 32'd0);
    chk("mrst_mix_r", 32'(mix_r), 32'd0);
    tick(2);
    rst = 1'b0;
    for (int v = 0; v < NV; v++) pan_m[v] = 2'b11;
    tick(1);
    run_frame(1'b1);

    // Randomized frames with ack delays, spurious acks and pan changes.
    noise_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int v = 0; v < NV; v++) begin
        samp_m[v] = $urandom_range(0, 255) - 128;
        dly_m[v] = $urandom_range(0, 3);
      end
      repeat ($urandom_range(0, 2)) cfg_write(2'($urandom_range(0, NV - 1)), 2'($urandom));
      run_frame(1'b0);
      tick($urandom_range(0, 3));
    end
    chk("rand_no_overrun", 32'(overrun), 32'd0);

`ifdef PSG_SCHED_TIMEOUT_EN
    // Voice 2 never acks: counted as 0, timeout raised, flag_clr clears it.
    silent_m[2] = 1'b1;
    run_frame(1'b0);
    chk("to_set", 32'(timeout), 32'd1);
    clear_flags();
    chk("to_clr", 32'(timeout), 32'd0);
    silent_m[2] = 1'b0;
`else
    chk("timeout_tied", 32'(timeout), 32'd0);
`endif

    noise_en = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
